// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and sync polarity codes
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int CNT_W_DEF     = 10;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    // Pixels (or lines) in one full period of an axis
    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with wrap, active and sync flags
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   VISIBLE = H_VISIBLE_DEF,
    parameter int   FRONT   = H_FRONT_DEF,
    parameter int   SYNC    = H_SYNC_DEF,
    parameter int   BACK    = H_BACK_DEF,
    parameter logic POL     = SYNC_ACT_LOW,
    parameter int   W       = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int             TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam int             SYNC_START = VISIBLE + FRONT;
    localparam int             SYNC_END   = SYNC_START + SYNC;
    localparam logic [W-1:0]   LAST       = W'(TOTAL - 1);

    if (TOTAL > (1 << W) || SYNC == 0) begin : g_bad_cfg
        $error("vga_axis_counter: total %0d does not fit %0d bits, or sync width is zero", TOTAL, W);
    end

    logic [W-1:0] count_q, count_d;
    logic         active_q, active_d;
    logic         sync_q, sync_d;

    // Next position plus the flags that will describe it, so both register together
    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        active_d = int'(count_d) < VISIBLE;
        sync_d   = (int'(count_d) >= SYNC_START && int'(count_d) < SYNC_END) ? POL : ~POL;
    end

    // Position and flags live in one register stage; reset lands on position 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= 1'b1;
            sync_q   <= ~POL;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_CE_EN adds the pix_ce pixel enable
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FRONT   = H_FRONT_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BACK    = H_BACK_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter logic HSYNC_POL = SYNC_ACT_LOW,
    parameter logic VSYNC_POL = SYNC_ACT_LOW,
    parameter int   CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef VGA_TIMING_CE_EN
    input  logic             pix_ce,
`endif
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    logic adv;
    logic h_wrap, v_wrap;
    logic h_active, v_active;

`ifdef VGA_TIMING_CE_EN
    assign adv = pix_ce;
`else
    assign adv = 1'b1;
`endif

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL),
        .W       (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv),
        .count  (hcount),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (hsync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL),
        .W       (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (h_wrap),
        .count  (vcount),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (vsync)
    );

    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Strobes follow the wrap into position 0 and hold across non-advancing edges
    always_comb begin
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        frame_cnt_d   = frame_cnt_q;
        if (adv) begin
            line_start_d  = h_wrap;
            frame_start_d = v_wrap;
        end
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Strobe and frame counter registers, aligned with the axis counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_cnt_q   <= 8'd0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Both operands are flops loaded on the same edge, so video_on adds no skew
    assign video_on    = h_active & v_active;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n, ce_a, ce_b;
    logic [9:0] a_hcount, a_vcount;
    logic       a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic [7:0] a_frame_cnt;
    logic [3:0] b_hcount, b_vcount;
    logic       b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic [7:0] b_frame_cnt;

    int checks = 0;
    int passed = 0;
    int eh = 0, ev = 0, efc = 0;
    int bh = 0, bv = 0, bfc = 0;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_a_n),
`ifdef VGA_TIMING_CE_EN
        .pix_ce(ce_a),
`endif
        .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
        .video_on(a_video_on), .line_start(a_line_start), .frame_start(a_frame_start),
        .frame_cnt(a_frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst_n(rst_b_n),
`ifdef VGA_TIMING_CE_EN
        .pix_ce(ce_b),
`endif
        .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
        .video_on(b_video_on), .line_start(b_line_start), .frame_start(b_frame_start),
        .frame_cnt(b_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_a_n) begin
            eh = 0; ev = 0; efc = 0;
        end else if (ce_a) begin
            eh++;
            if (eh == 800) begin
                eh = 0; ev++;
                if (ev == 525) begin ev = 0; efc = (efc + 1) % 256; end
            end
        end
        if (!rst_b_n) begin
            bh = 0; bv = 0; bfc = 0;
        end else if (ce_b) begin
            bh++;
            if (bh == 8) begin
                bh = 0; bv++;
                if (bv == 6) begin bv = 0; bfc = (bfc + 1) % 256; end
            end
        end
        @(negedge clk);
    endtask

    function automatic int a_bad();
        int n = 0;
        if (int'(a_hcount) != eh) n++;
        if (int'(a_vcount) != ev) n++;
        if (a_hsync !== (eh < 656 || eh >= 752)) n++;
        if (a_vsync !== (ev < 490 || ev >= 492)) n++;
        if (a_video_on !== (eh < 640 && ev < 480)) n++;
        if (a_line_start !== (eh == 0)) n++;
        if (a_frame_start !== (eh == 0 && ev == 0)) n++;
        if (int'(a_frame_cnt) != efc) n++;
        return n;
    endfunction

    function automatic int b_bad();
        int n = 0;
        if (int'(b_hcount) != bh) n++;
        if (int'(b_vcount) != bv) n++;
        if (b_hsync !== (bh >= 5 && bh < 7)) n++;
        if (b_vsync !== (bv == 4)) n++;
        if (b_video_on !== (bh < 4 && bv < 3)) n++;
        if (b_line_start !== (bh == 0)) n++;
        if (b_frame_start !== (bh == 0 && bv == 0)) n++;
        if (int'(b_frame_cnt) != bfc) n++;
        return n;
    endfunction

    initial begin
        int a_mis = 0, b_mis = 0;
        int a_low = 0, a_lowmin = 9999, a_lowmax = -1, a_ls = 0, a_ls_last = -1, a_period = -1;
        int b_von = 0, b_hhi = 0, b_hmin = 99, b_hmax = -1, b_vhi = 0, b_fs = 0;

        rst_a_n = 1'b0; rst_b_n = 1'b0; ce_a = 1'b1; ce_b = 1'b1;
        tick(); tick();
        check("a_rst_hcount", a_hcount, 0);
        check("a_rst_vcount", a_vcount, 0);
        check("a_rst_frame_cnt", a_frame_cnt, 0);
        check("a_rst_video_on", a_video_on, 1);
        check("a_rst_line_start", a_line_start, 1);
        check("a_rst_frame_start", a_frame_start, 1);
        check("a_rst_hsync", a_hsync, 1);
        check("a_rst_vsync", a_vsync, 1);
        check("b_rst_hsync", b_hsync, 0);
        check("b_rst_vsync", b_vsync, 0);
        check("b_rst_video_on", b_video_on, 1);

        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();
        check("a_first_hcount", a_hcount, 1);
        check("a_first_vcount", a_vcount, 0);
        check("a_first_line_start", a_line_start, 0);
        check("a_first_frame_start", a_frame_start, 0);
        check("b_first_hcount", b_hcount, 1);

        for (int i = 0; i < 1650; i++) begin
            tick();
            a_mis += a_bad();
            b_mis += b_bad();
            if (i < 800) begin
                if (!a_hsync) begin
                    a_low++;
                    if (int'(a_hcount) < a_lowmin) a_lowmin = int'(a_hcount);
                    if (int'(a_hcount) > a_lowmax) a_lowmax = int'(a_hcount);
                end
                if (a_line_start) a_ls++;
            end
            if (a_line_start) begin
                if (a_ls_last >= 0 && a_period < 0) a_period = i - a_ls_last;
                a_ls_last = i;
            end
            if (i < 48) begin
                if (b_video_on) b_von++;
                if (b_hsync) begin
                    b_hhi++;
                    if (int'(b_hcount) < b_hmin) b_hmin = int'(b_hcount);
                    if (int'(b_hcount) > b_hmax) b_hmax = int'(b_hcount);
                end
                if (b_vsync) b_vhi++;
                if (b_frame_start) b_fs++;
            end
            if (i == 94) begin
                check("b_frame_cnt_after_96", b_frame_cnt, 2);
                check("b_hcount_after_96", b_hcount, 0);
                check("b_frame_start_after_96", b_frame_start, 1);
            end
        end
        check("a_model_mismatches", a_mis, 0);
        check("b_model_mismatches", b_mis, 0);
        check("a_hsync_low_count", a_low, 96);
        check("a_hsync_low_first", a_lowmin, 656);
        check("a_hsync_low_last", a_lowmax, 751);
        check("a_line_start_per_line", a_ls, 1);
        check("a_line_period", a_period, 800);
        check("b_video_on_per_frame", b_von, 12);
        check("b_hsync_high_count", b_hhi, 12);
        check("b_hsync_high_first", b_hmin, 5);
        check("b_hsync_high_last", b_hmax, 6);
        check("b_vsync_high_count", b_vhi, 8);
        check("b_frame_start_per_frame", b_fs, 1);

        for (int k = 0; k < 2000; k++) begin
            if (eh == 300 && ev == 2) break;
            tick();
        end
        check("a_pre_reset_hcount", a_hcount, 300);
        check("a_pre_reset_vcount", a_vcount, 2);
        rst_a_n = 1'b0;
        tick();
        check("a_midrst_hcount", a_hcount, 0);
        check("a_midrst_vcount", a_vcount, 0);
        check("a_midrst_frame_start", a_frame_start, 1);
        check("a_midrst_frame_cnt", a_frame_cnt, 0);
        rst_a_n = 1'b1;
        tick();
        check("a_postrst_hcount", a_hcount, 1);
        check("a_postrst_vcount", a_vcount, 0);

        for (int k = 0; k < 100; k++) begin
            if (bh == 5 && bv == 2) break;
            tick();
        end
        check("b_pre_reset_hcount", b_hcount, 5);
        check("b_pre_reset_vcount", b_vcount, 2);
        rst_b_n = 1'b0;
        tick();
        check("b_midrst_hcount", b_hcount, 0);
        check("b_midrst_vcount", b_vcount, 0);
        check("b_midrst_frame_cnt", b_frame_cnt, 0);
        check("b_midrst_frame_start", b_frame_start, 1);
        rst_b_n = 1'b1;
        tick();
        check("b_postrst_hcount", b_hcount, 1);

`ifdef VGA_TIMING_CE_EN
        begin
            int rise1 = -1, rise2 = -1, ls_hi = 0, hold_bad = 0, mis = 0, fc_before;
            logic prev_ls;
            logic [31:0] snap;
            prev_ls = a_line_start;
            for (int i = 0; i < 8000; i++) begin
                ce_a = (i % 4 == 0);
                snap = {a_hcount, a_vcount, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_frame_cnt[6:0]};
                tick();
                mis += a_bad();
                if (!ce_a && snap !== {a_hcount, a_vcount, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_frame_cnt[6:0]})
                    hold_bad++;
                if (a_line_start && !prev_ls) begin
                    if (rise1 < 0) rise1 = i;
                    else begin rise2 = i; break; end
                end
                if (rise1 >= 0 && a_line_start) ls_hi++;
                prev_ls = a_line_start;
            end
            ce_a = 1'b1;
            check("ce_line_period", rise2 - rise1, 3200);
            check("ce_line_start_clks", ls_hi, 4);
            check("ce_hold_changes", hold_bad, 0);
            check("ce_model_mismatches", mis, 0);

            for (int k = 0; k < 100; k++) begin
                if (bh == 7 && bv == 5) break;
                tick();
            end
            check("b_prewrap_hcount", b_hcount, 7);
            check("b_prewrap_vcount", b_vcount, 5);
            fc_before = bfc;
            ce_b = 1'b0;
            tick();
            check("b_hold_hcount", b_hcount, 7);
            check("b_hold_vcount", b_vcount, 5);
            check("b_hold_frame_cnt", b_frame_cnt, fc_before);
            ce_b = 1'b1;
            tick();
            check("b_wrap_hcount", b_hcount, 0);
            check("b_wrap_vcount", b_vcount, 0);
            check("b_wrap_frame_cnt", b_frame_cnt, (fc_before + 1) % 256);
            check("b_wrap_frame_start", b_frame_start, 1);
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48: horizontal porch, sync and back-porch widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-004 Parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33: vertical porch, sync and back-porch widths in lines.
REQ-005 Parameters HSYNC_POL and VSYNC_POL, default 0 each: asserted sync level (0 = active-low).
REQ-006 Parameter CNT_W, default 10: width of hcount and vcount.
REQ-007 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-008 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 Port pix_ce, input, 1: pixel-advance enable (present only with VGA_TIMING_CE_EN).
REQ-010 Ports hcount and vcount, output, CNT_W each: current pixel column and line.
REQ-011 Ports hsync and vsync, output, 1 each: sync outputs at the configured polarity.
REQ-012 Port video_on, output, 1: high while the current pixel is inside the visible area.
REQ-013 Ports line_start and frame_start, output, 1 each: one-pixel strobes.
REQ-014 Port frame_cnt, output, 8: count of completed frames, wrapping.

Function
REQ-015 H_TOTAL SHALL be H_VISIBLE+H_FRONT+H_SYNC+H_BACK, and V_TOTAL the vertical equivalent.
REQ-016 All outputs SHALL be registered and describe the same pixel (hcount, vcount) in the same cycle, with zero skew between counters and flags.
REQ-017 On each advancing edge, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-018 vcount SHALL wrap from V_TOTAL-1 to 0 on the edge where hcount also wraps, and frame_cnt SHALL increment modulo 256 on that same edge.
REQ-019 hsync SHALL equal HSYNC_POL when hcount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), and ~HSYNC_POL otherwise.
REQ-020 vsync SHALL equal VSYNC_POL when vcount is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), and ~VSYNC_POL otherwise.
REQ-021 video_on SHALL be high when hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-022 line_start SHALL be high when hcount==0; frame_start SHALL be high when hcount==0 and vcount==0.
REQ-023 A non-advancing edge SHALL hold every output unchanged, so a strobe lasts exactly one pixel, not one clk.
REQ-024 An elaboration error SHALL be raised if H_TOTAL or V_TOTAL exceeds 2**CNT_W, or if any sync width is 0.

Reset
REQ-025 While rst_n is low at a clk edge, outputs SHALL load: hcount=0, vcount=0, frame_cnt=0, video_on=1, line_start=1, frame_start=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-026 Reset SHALL take priority over pix_ce, and asserting it mid-frame SHALL restart timing at pixel (0,0).
REQ-027 The first advancing edge after release SHALL present pixel (1,0).

Configuration
REQ-028 Macro VGA_TIMING_CE_EN: when defined, the pix_ce port SHALL exist and an edge SHALL advance only when pix_ce=1.
REQ-029 Without VGA_TIMING_CE_EN, the pix_ce port SHALL be absent and every clk edge SHALL advance.

Structure
REQ-030 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants and the sync-polarity constants SYNC_ACT_LOW and SYNC_ACT_HIGH.
REQ-031 Sub-module vga_axis_counter (params VISIBLE, FRONT, SYNC, BACK, POL, W; outputs count, wrap, active, sync) SHALL be instantiated twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-032 Defaults, pix_ce tied 1, run 2 frames -> hsync low for exactly hcount 656..751, line period 800 clk, frame period 420000 clk.
REQ-033 Defaults -> vsync low exactly on vcount 490..491, frame_start once per 420000 clk, frame_cnt=2 after 840000 advancing edges.
REQ-034 HSYNC_POL=1, VSYNC_POL=1, timing 4/1/2/1 and 3/1/1/1 -> hsync high at hcount 5..6, H_TOTAL=8, V_TOTAL=6, video_on count=12 per frame.
REQ-035 pix_ce=1 every 4th clk -> outputs change only on enabled edges; line_start high for 4 clk; line period 3200 clk.
REQ-036 rst_n low for 1 clk at (hcount=300, vcount=200) -> next cycle shows (0,0), frame_start=1, frame_cnt=0; the following advancing edge shows (1,0).
REQ-037 Wrap at (799,524) coinciding with pix_ce=0 -> hold; next enabled edge shows (0,0), frame_cnt incremented by 1.
